// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin multiplexer: arbitration modes and
// the select-index width helper.
package mux_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // A one-bit index is still needed when there are only one or two channels.
    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter, round-robin or fixed priority.
// Owns the last-grant pointer, which moves only when the caller accepts a grant.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int FIXED = 0,
    localparam int SEL_W = sel_w(N)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0] last_grant_q, last_grant_d;
    logic             found;

    // Scanning from lowest to highest priority and overwriting leaves the
    // highest-priority requester as the final winner.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        if (FIXED == int'(ARB_FIXED)) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant_idx = SEL_W'(i);
                    found     = 1'b1;
                end
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                if (req[(int'(last_grant_q) + k) % N]) begin
                    grant_idx = SEL_W'((int'(last_grant_q) + k) % N);
                    found     = 1'b1;
                end
            end
        end
    end

    assign grant = found ? (N'(1) << grant_idx) : '0;

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance) begin
            last_grant_d = grant_idx;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_grant_q <= SEL_W'(N - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered multiplexer with valid/ready on every port.
// One output register stage; loads and drains on the same edge for full throughput.
module rr_mux_n
    import mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int FIXED = 0,
    localparam int SEL_W = sel_w(N)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*W-1:0]   Din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     Dout,
    output logic [SEL_W-1:0] out_sel
);

    logic [N-1:0][W-1:0] din_a;
    logic [N-1:0]        grant;
    logic [SEL_W-1:0]    grant_idx;
    logic                room;
    logic                load;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     dout_q, dout_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    assign din_a = Din;

    rr_arbiter #(
        .N     (N),
        .FIXED (FIXED)
    ) u_arb (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (in_valid),
        .advance   (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The register can take a word if it is empty or its word leaves this edge.
    assign room     = !out_valid_q || out_ready;
    assign load     = (|in_valid) && room;
    assign in_ready = grant & {N{room}};

    always_comb begin
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = 1'b1;
            dout_d      = din_a[grant_idx];
            out_sel_d   = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Dout      = dout_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Runs a round-robin and a fixed-priority instance side by side on shared
// stimulus and compares both against a queue-based priority model.
module tb_rr_mux_n;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   iv  = '0;
    logic [N*W-1:0] din = '0;
    logic           ordy = 1'b0;

    logic [N-1:0] rdy_rr, rdy_fx;
    logic         ov_rr, ov_fx;
    logic [W-1:0] do_rr, do_fx;
    logic [1:0]   sel_rr, sel_fx;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: index 0 = round-robin instance, 1 = fixed-priority instance.
    int order[$];
    bit m_ov[2];
    int m_dout[2];
    int m_sel[2];

    rr_mux_n #(.N(N), .W(W), .FIXED(0)) u_rr (
        .Clk(clk), .Reset(rst), .in_valid(iv), .in_ready(rdy_rr), .Din(din),
        .out_valid(ov_rr), .out_ready(ordy), .Dout(do_rr), .out_sel(sel_rr)
    );

    rr_mux_n #(.N(N), .W(W), .FIXED(1)) u_fx (
        .Clk(clk), .Reset(rst), .in_valid(iv), .in_ready(rdy_fx), .Din(din),
        .out_valid(ov_fx), .out_ready(ordy), .Dout(do_fx), .out_sel(sel_fx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Round-robin keeps channels in current priority order, last winner at the tail.
    function automatic int pick(input int m, input logic [N-1:0] v);
        if (m == 1) begin
            for (int i = 0; i < N; i++) if (v[i]) return i;
        end else begin
            foreach (order[k]) if (v[order[k]]) return order[k];
        end
        return -1;
    endfunction

    task automatic model_reset();
        order = '{0, 1, 2, 3};
        for (int m = 0; m < 2; m++) begin
            m_ov[m]   = 1'b0;
            m_dout[m] = 0;
            m_sel[m]  = 0;
        end
    endtask

    task automatic check_outs(input string pfx);
        chk({pfx, "_rr_valid"}, 32'(ov_rr),  32'(m_ov[0]));
        chk({pfx, "_rr_dout"},  32'(do_rr),  m_dout[0]);
        chk({pfx, "_rr_sel"},   32'(sel_rr), m_sel[0]);
        chk({pfx, "_fx_valid"}, 32'(ov_fx),  32'(m_ov[1]));
        chk({pfx, "_fx_dout"},  32'(do_fx),  m_dout[1]);
        chk({pfx, "_fx_sel"},   32'(sel_fx), m_sel[1]);
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
        int  g[2];
        bit  ld[2];
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        iv = v; din = d; ordy = r;
        #1;
        for (int m = 0; m < 2; m++) begin
            g[m]    = pick(m, v);
            ld[m]   = (v != 0) && (!m_ov[m] || r);
            exp_rdy = ld[m] ? N'(1 << g[m]) : '0;
            chk(m == 0 ? "rr_in_ready" : "fx_in_ready", 32'(m == 0 ? rdy_rr : rdy_fx), 32'(exp_rdy));
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (ld[m]) begin
                m_ov[m]   = 1'b1;
                m_dout[m] = int'(d[g[m]*W +: W]);
                m_sel[m]  = g[m];
                if (m == 0) while (order[$] != g[m]) order.push_back(order.pop_front());
            end else if (r) begin
                m_ov[m] = 1'b0;
            end
        end
        #1;
        check_outs("out");
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single requester.
        step(4'b0100, 32'h00A5_0000, 1'b1);
        chk("single_sel", 32'(sel_rr), 32'd2);
        step(4'b0000, 32'h0, 1'b1);

        // Asynchronous reset while a word is held.
        step(4'b0001, 32'h0000_0011, 1'b0);
        #2;
        iv = '0;
        rst = 1'b1;
        #1;
        model_reset();
        check_outs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111, 32'h1312_1110, 1'b1);
        chk("rst_first_grant", 32'(sel_rr), 32'd0);

        // Full rotation with no bubbles.
        repeat (6) step(4'b1111, 32'h1312_1110, 1'b1);

        // Backpressure, then release.
        repeat (3) step(4'b1111, 32'h2322_2120, 1'b0);
        repeat (2) step(4'b1111, 32'h3332_3130, 1'b1);

        // Fixed priority picks ch1 until it drops.
        repeat (3) step(4'b1010, 32'h4342_4140, 1'b1);
        chk("fixed_ch1", 32'(sel_fx), 32'd1);
        step(4'b1000, 32'h5352_5150, 1'b1);
        chk("fixed_ch3", 32'(sel_fx), 32'd3);

        // Skip and wrap of the round-robin pointer.
        step(4'b1000, 32'h6362_6160, 1'b1);
        step(4'b0010, 32'h7372_7170, 1'b1);
        chk("wrap_ch1", 32'(sel_rr), 32'd1);
        step(4'b1001, 32'h8382_8180, 1'b1);
        chk("skip_ch3", 32'(sel_rr), 32'd3);
        step(4'b0000, 32'h0, 1'b1);

        repeat (400) step(N'($urandom), $urandom, ($urandom_range(0, 3) != 0));
        repeat (3) step(4'b0000, $urandom, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
